// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Contents: arbiter state encoding and the owner select encoding driven on sel.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StOwnIf = 2'd1,
    StOwnDm = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (IF, DM) and memory-side signals around the memory port arbiter.
// slave  : arbiter view (takes requests and memory responses, drives grants/done/memory port).
// master : environment view (requesters plus the memory).
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          sel;
  logic          err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, sel, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_gnt, if_done, if_rdata, dm_gnt, dm_done, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, sel, err
  );
endinterface

// File: rtl/arb_wait_timer.sv
// Counts consecutive cycles an access has waited for mem_ready.
// clear_i   : zero the count (held while no access is in flight)
// tick_i    : one more cycle waited without ready
// expired_o : the current cycle is the WAIT_MAX-th waiting cycle
module arb_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);
  localparam int unsigned CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds cycles already waited, so expiry is visible combinationally in the
  // last allowed cycle, letting a same-cycle mem_ready take priority over the abort.
  assign expired_o = (cnt_q == CW'(WAIT_MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i && !expired_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF) and data
// memory (DM). One transaction in flight; the winner's request is latched onto the port.
// clk, rst_n : clock and asynchronous active-low reset
// bus        : requester handshakes, memory port, sel (owner mux select) and err (timeout)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);
  arb_state_e    state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic          sel_q, sel_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          own;
  logic          owner;
  logic          expired;

  assign own   = (state_q == StOwnIf) || (state_q == StOwnDm);
  assign owner = (state_q == StOwnDm) ? OWNER_DM : OWNER_IF;

  arb_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!own),
    .tick_i    (own && !bus.mem_ready),
    .expired_o (expired)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    sel_d        = sel_q;
    err_d        = 1'b0;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    unique case (state_q)
      StIdle: begin
        // On a tie the side that did not own the port last time wins.
        if (bus.if_req && (!bus.dm_req || last_owner_q == OWNER_DM)) begin
          state_d = StOwnIf;
          sel_d   = OWNER_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
        end else if (bus.dm_req) begin
          state_d = StOwnDm;
          sel_d   = OWNER_DM;
          we_d    = bus.dm_we;
          addr_d  = bus.dm_addr;
          wdata_d = bus.dm_wdata;
        end
      end
      StOwnIf, StOwnDm: begin
        if (bus.mem_ready) begin
          if (!we_q) begin
            if (owner == OWNER_DM) dm_rdata_d = bus.mem_rdata;
            else                   if_rdata_d = bus.mem_rdata;
          end
          last_owner_d = owner;
          state_d      = StResp;
        end else if (expired) begin
          err_d        = 1'b1;
          last_owner_d = owner;
          state_d      = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_owner_q <= OWNER_DM;
      sel_q        <= OWNER_IF;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      sel_q        <= sel_d;
      err_q        <= err_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  // last_owner_q is already updated to the finishing owner when RESP is entered.
  assign bus.if_gnt    = (state_q == StOwnIf);
  assign bus.dm_gnt    = (state_q == StOwnDm);
  assign bus.if_done   = (state_q == StResp) && (last_owner_q == OWNER_IF);
  assign bus.dm_done   = (state_q == StResp) && (last_owner_q == OWNER_DM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = own;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.sel       = sel_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single IF read, tie rotation, delayed DM write,
// timeout abort, ready in the last allowed cycle, and reset mid-access.
module tb_mem_port_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW       (32),
    .DW       (32),
    .WAIT_MAX (15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.if_req = 1'b0;  bus.if_addr  = '0;
    bus.dm_req = 1'b0;  bus.dm_we    = 1'b0;
    bus.dm_addr = '0;   bus.dm_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_dm_gnt", bus.dm_gnt, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_err", bus.err, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    rst_n = 1'b1;
    step();

    // Single IF read, ready in the first OWN cycle.
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
    step();
    check("t1_if_gnt", bus.if_gnt, 1);
    check("t1_dm_gnt", bus.dm_gnt, 0);
    check("t1_mem_req", bus.mem_req, 1);
    check("t1_mem_addr", bus.mem_addr, 32'h0000_0040);
    check("t1_mem_we", bus.mem_we, 0);
    check("t1_sel", bus.sel, 0);
    check("t1_if_done_early", bus.if_done, 0);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h2002_0005; bus.if_req = 1'b0;
    step();
    check("t1_if_done", bus.if_done, 1);
    check("t1_if_gnt_resp", bus.if_gnt, 0);
    check("t1_mem_req_resp", bus.mem_req, 0);
    check("t1_if_rdata", bus.if_rdata, 32'h2002_0005);
    check("t1_err", bus.err, 0);
    check("t1_dm_done", bus.dm_done, 0);
    bus.mem_ready = 1'b0;
    step();
    check("t1_if_done_after", bus.if_done, 0);

    // Reset pulse restores last_owner=DM so the first tie goes to IF.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    check("t2_if_rdata_cleared", bus.if_rdata, 0);

    // Three tie rounds with both requests held high: IF, DM, IF.
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0100;
    for (int r = 0; r < 3; r++) begin
      step();
      check("t2_if_gnt", bus.if_gnt, (r == 1) ? 0 : 1);
      check("t2_dm_gnt", bus.dm_gnt, (r == 1) ? 1 : 0);
      check("t2_sel", bus.sel, (r == 1) ? 1 : 0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_0000 + r;
      step();
      check("t2_if_done", bus.if_done, (r == 1) ? 0 : 1);
      check("t2_dm_done", bus.dm_done, (r == 1) ? 1 : 0);
      check("t2_no_gnt", {bus.if_gnt, bus.dm_gnt}, 0);
      bus.mem_ready = 1'b0;
      step();
      if (r == 2) begin
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
      end
    end
    check("t2_if_rdata", bus.if_rdata, 32'h1111_0002);
    check("t2_dm_rdata", bus.dm_rdata, 32'h1111_0001);

    // DM write, ready four cycles after grant: mem_req held five cycles.
    bus.dm_req = 1'b1; bus.dm_we = 1'b1;
    bus.dm_addr = 32'h0000_1000; bus.dm_wdata = 32'hCAFE_F00D;
    step();
    check("t3_dm_gnt", bus.dm_gnt, 1);
    check("t3_sel", bus.sel, 1);
    check("t3_mem_we", bus.mem_we, 1);
    check("t3_mem_addr", bus.mem_addr, 32'h0000_1000);
    check("t3_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t3_mem_req_held", bus.mem_req, 1);
      check("t3_addr_stable", bus.mem_addr, 32'h0000_1000);
      check("t3_wdata_stable", bus.mem_wdata, 32'hCAFE_F00D);
      check("t3_no_done", bus.dm_done, 0);
    end
    bus.mem_ready = 1'b1;
    step();
    check("t3_dm_done", bus.dm_done, 1);
    check("t3_mem_req_drop", bus.mem_req, 0);
    check("t3_dm_rdata_kept", bus.dm_rdata, 32'h1111_0001);
    check("t3_err", bus.err, 0);
    bus.mem_ready = 1'b0;
    step();
    check("t3_done_after", bus.dm_done, 0);

    // DM read that never gets ready: abort in the 15th OWN cycle, then a pending IF.
    bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_2000;
    step();
    bus.dm_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h0000_0080;
    for (int n = 1; n <= 15; n++) begin
      check("t4_dm_gnt_wait", bus.dm_gnt, 1);
      check("t4_no_done_wait", bus.dm_done, 0);
      step();
    end
    check("t4_dm_done", bus.dm_done, 1);
    check("t4_err", bus.err, 1);
    check("t4_mem_req_drop", bus.mem_req, 0);
    check("t4_dm_rdata_kept", bus.dm_rdata, 32'h1111_0001);
    check("t4_if_gnt_resp", bus.if_gnt, 0);
    step();
    check("t4_err_cleared", bus.err, 0);
    check("t4_done_after", bus.dm_done, 0);
    step();
    check("t4_if_gnt", bus.if_gnt, 1);
    check("t4_if_addr", bus.mem_addr, 32'h0000_0080);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_F00D; bus.if_req = 1'b0;
    step();
    check("t4_if_done", bus.if_done, 1);
    check("t4_if_rdata", bus.if_rdata, 32'h0BAD_F00D);
    bus.mem_ready = 1'b0;
    step();

    // DM read with ready exactly in the 15th wait cycle: normal completion.
    bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_3000;
    step();
    bus.dm_req = 1'b0;
    repeat (14) step();
    check("t5_dm_gnt_last", bus.dm_gnt, 1);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A_1234;
    step();
    check("t5_dm_done", bus.dm_done, 1);
    check("t5_err", bus.err, 0);
    check("t5_dm_rdata", bus.dm_rdata, 32'h5A5A_1234);
    bus.mem_ready = 1'b0;
    step();

    // Reset in the second wait cycle of a DM access.
    bus.dm_req = 1'b1; bus.dm_addr = 32'h0000_4000;
    step();
    step();
    check("t6_dm_gnt", bus.dm_gnt, 1);
    check("t6_sel_dm", bus.sel, 1);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_00C0;
    rst_n = 1'b0;
    #1;
    check("t6_dm_gnt_rst", bus.dm_gnt, 0);
    check("t6_mem_req_rst", bus.mem_req, 0);
    check("t6_sel_rst", bus.sel, 0);
    check("t6_mem_addr_rst", bus.mem_addr, 0);
    check("t6_dm_rdata_rst", bus.dm_rdata, 0);
    check("t6_if_rdata_rst", bus.if_rdata, 0);
    check("t6_err_rst", bus.err, 0);
    check("t6_dm_done_rst", bus.dm_done, 0);
    step();
    check("t6_dm_done_held", bus.dm_done, 0);
    rst_n = 1'b1;
    step();
    check("t6_tie_if_gnt", bus.if_gnt, 1);
    check("t6_tie_dm_gnt", bus.dm_gnt, 0);
    check("t6_tie_addr", bus.mem_addr, 32'h0000_00C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
